pipe_elastic_stage: RTL and testbench

PIPE_ELASTIC_STAGE -- requirements
Module: pipe_elastic_stage

---
 rtl/pipe_elastic_stage.sv | 125 ++++++++++++
 tb/tb_pipe_elastic_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_elastic_stage.sv
// Two-entry elastic (skid) pipeline stage carrying a control bundle plus NLANE data lanes.
// Latency: one cycle from acceptance into an empty stage to appearing on the outputs.
// Backpressure: in_ready_o comes from registered state only, so there is no combinational path from out_ready_i.
module pipe_elastic_stage #(
    parameter int DATA_W  = 16,
    parameter int NLANE   = 5,
    parameter int CTRL_W  = 11,
    parameter int STALL_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [CTRL_W-1:0]        in_ctrl_i,
    input  logic [DATA_W*NLANE-1:0]  in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [CTRL_W-1:0]        out_ctrl_o,
    output logic [DATA_W*NLANE-1:0]  out_data_o,
    output logic [1:0]               occ_o,
    output logic [STALL_W-1:0]       stall_cnt_o
);

    localparam int DW = DATA_W * NLANE;

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CTRL_W-1:0]    main_ctrl_q, main_ctrl_d;
    logic [CTRL_W-1:0]    skid_ctrl_q, skid_ctrl_d;
    logic [DW-1:0]        main_data_q, main_data_d;
    logic [DW-1:0]        skid_data_q, skid_data_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic                 accept;
    logic                 pop;

    assign in_ready_o  = (state_q != ST_TWO);
    assign out_valid_o = (state_q != ST_EMPTY);
    // Bubbles carry zero control, so a downstream stage never sees stale write enables.
    assign out_ctrl_o  = out_valid_o ? main_ctrl_q : '0;
    assign out_data_o  = main_data_q;
    assign occ_o       = state_q;
    assign stall_cnt_o = stall_q;

    assign accept = in_valid_i & in_ready_o;
    assign pop    = out_valid_o & out_ready_i;

    // Next-state and datapath steering; flush overrides both accept and pop.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush_i) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (accept && !pop) begin
                        state_d     = ST_TWO;
                        skid_ctrl_d = in_ctrl_i;
                        skid_data_d = in_data_i;
                    end else if (!accept && pop) begin
                        state_d     = ST_EMPTY;
                    end else if (accept && pop) begin
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Stall counter saturates instead of wrapping; flush does not affect it.
    always_comb begin
        stall_d = stall_q;
        if (out_valid_o && !out_ready_i && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_q     <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Bench for pipe_elastic_stage: directed scenarios plus random traffic against a queue model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// The model is a bounded FIFO (capacity 2) with a saturating stall count.
module tb_pipe_elastic_stage;

    localparam int DATA_W  = 16;
    localparam int NLANE   = 5;
    localparam int CTRL_W  = 11;
    localparam int STALL_W = 4;
    localparam int DW      = DATA_W * NLANE;
    localparam int SMAX    = (1 << STALL_W) - 1;

    logic               clk_i;
    logic               rst_n;
    logic               flush_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [CTRL_W-1:0]  in_ctrl_i;
    logic [DW-1:0]      in_data_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [CTRL_W-1:0]  out_ctrl_o;
    logic [DW-1:0]      out_data_o;
    logic [1:0]         occ_o;
    logic [STALL_W-1:0] stall_cnt_o;

    pipe_elastic_stage #(
        .DATA_W (DATA_W),
        .NLANE  (NLANE),
        .CTRL_W (CTRL_W),
        .STALL_W(STALL_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_ctrl_i  (in_ctrl_i),
        .in_data_i  (in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_ctrl_o (out_ctrl_o),
        .out_data_o (out_data_o),
        .occ_o      (occ_o),
        .stall_cnt_o(stall_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DW-1:0]     d;
    } ent_t;

    ent_t m_q[$];
    int   m_stall;
    int   nvec;
    int   nfail;

    localparam int SW = 1 + 1 + 2 + CTRL_W + STALL_W;

    // Expected {valid, ready, occ, ctrl, stall} derived from the FIFO model.
    function automatic logic [SW-1:0] exp_vec();
        logic               v;
        logic               r;
        logic [1:0]         o;
        logic [CTRL_W-1:0]  c;
        v = (m_q.size() > 0);
        r = (m_q.size() < 2);
        o = 2'(m_q.size());
        c = v ? m_q[0].c : '0;
        return {v, r, o, c, STALL_W'(m_stall)};
    endfunction

    function automatic logic [DW-1:0] exp_data();
        return (m_q.size() > 0) ? m_q[0].d : '0;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        d[31:0]  = $urandom();
        d[63:32] = $urandom();
        d[79:64] = 16'($urandom());
        return d;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        bit v;
        bit r;
        v = (m_q.size() > 0);
        r = (m_q.size() < 2);
        if (v && !out_ready_i && m_stall < SMAX) m_stall++;
        if (flush_i) begin
            m_q.delete();
        end else begin
            if (v && out_ready_i) void'(m_q.pop_front());
            if (in_valid_i && r) m_q.push_back('{in_ctrl_i, in_data_i});
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_stall = 0;
    endtask

    // Drive one cycle of inputs, clock it, update the model, return at the falling edge.
    task automatic cyc(input logic fl, input logic iv, input logic [CTRL_W-1:0] c,
                       input logic [DW-1:0] d, input logic rdy);
        flush_i     = fl;
        in_valid_i  = iv;
        in_ctrl_i   = c;
        in_data_i   = d;
        out_ready_i = rdy;
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush_i = 1'b0; in_valid_i = 1'b0; in_ctrl_i = '0; in_data_i = '0; out_ready_i = 1'b0;
        model_reset();
        #3;
        nvec++;
        if ({out_valid_o, occ_o, out_ctrl_o, out_data_o, stall_cnt_o} !== '0) begin
            nfail++;
            $display("FAIL reset_outputs got vld=%b occ=%0d ctrl=%h data=%h stall=%0d exp all zero",
                     out_valid_o, occ_o, out_ctrl_o, out_data_o, stall_cnt_o);
        end
        @(negedge clk_i);
        rst_n = 1'b1;
        #1;
        nvec++;
        if (in_ready_o !== 1'b1) begin
            nfail++;
            $display("FAIL reset_ready got=%b exp=1", in_ready_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_pass_through();
        logic [DW-1:0] d;
        d = rnd_data();
        d[15:0] = 16'h1234;
        cyc(0, 1, 11'h7FF, d, 1);
        nvec++;
        if (out_valid_o !== 1'b1 || out_ctrl_o !== 11'h7FF || out_data_o[15:0] !== 16'h1234 || occ_o !== 2'd1) begin
            nfail++;
            $display("FAIL pass_first got vld=%b ctrl=%h lane0=%h occ=%0d exp 1/7ff/1234/1",
                     out_valid_o, out_ctrl_o, out_data_o[15:0], occ_o);
        end
        for (int i = 0; i < 8; i++) begin
            d = rnd_data();
            d[15:0] = 16'h0100 + 16'(i);
            cyc(0, 1, CTRL_W'(i + 1), d, 1);
            nvec++;
            if ({out_valid_o, in_ready_o, occ_o, out_ctrl_o, stall_cnt_o} !== exp_vec()
                || out_data_o !== exp_data() || out_data_o[15:0] !== 16'h0100 + 16'(i)) begin
                nfail++;
                $display("FAIL pass_stream[%0d] got st=%h lane0=%h exp st=%h lane0=%h",
                         i, {out_valid_o, in_ready_o, occ_o, out_ctrl_o, stall_cnt_o},
                         out_data_o[15:0], exp_vec(), 16'h0100 + 16'(i));
            end
        end
        cyc(0, 0, '0, '0, 1);
    endtask

    task automatic test_backpressure();
        logic [15:0] seen[$];
        cyc(0, 1, 11'h001, DW'(16'h0001), 0);
        cyc(0, 1, 11'h002, DW'(16'h0002), 0);
        cyc(0, 1, 11'h003, DW'(16'h0003), 0);
        nvec++;
        if (occ_o !== 2'd2 || in_ready_o !== 1'b0 || out_data_o[15:0] !== 16'h0001
            || {out_valid_o, in_ready_o, occ_o, out_ctrl_o, stall_cnt_o} !== exp_vec()) begin
            nfail++;
            $display("FAIL bp_full got occ=%0d rdy=%b lane0=%h exp occ=2 rdy=0 lane0=0001",
                     occ_o, in_ready_o, out_data_o[15:0]);
        end
        for (int i = 0; i < 4; i++) begin
            if (out_valid_o) seen.push_back(out_data_o[15:0]);
            if (i < 2) cyc(0, 1, 11'h003, DW'(16'h0003), 1);
            else       cyc(0, 0, '0, '0, 1);
            nvec++;
            if ({out_valid_o, in_ready_o, occ_o, out_ctrl_o, stall_cnt_o} !== exp_vec()) begin
                nfail++;
                $display("FAIL bp_drain[%0d] got=%h exp=%h", i,
                         {out_valid_o, in_ready_o, occ_o, out_ctrl_o, stall_cnt_o}, exp_vec());
            end
        end
        nvec++;
        if (seen.size() != 3 || seen[0] !== 16'h0001 || seen[1] !== 16'h0002 || seen[2] !== 16'h0003) begin
            nfail++;
            $display("FAIL bp_order got %0d entries exp 0001,0002,0003", seen.size());
        end
    endtask

    task automatic test_flush();
        cyc(0, 1, 11'h00A, DW'(16'h000A), 0);
        cyc(0, 1, 11'h00B, DW'(16'h000B), 0);
        cyc(1, 1, 11'h00D, DW'(16'h000D), 0);
        nvec++;
        if (occ_o !== 2'd0 || out_valid_o !== 1'b0 || out_ctrl_o !== '0 || in_ready_o !== 1'b1) begin
            nfail++;
            $display("FAIL flush_empty got occ=%0d vld=%b ctrl=%h rdy=%b exp 0/0/000/1",
                     occ_o, out_valid_o, out_ctrl_o, in_ready_o);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, '0, '0, 1);
            nvec++;
            if (out_valid_o !== 1'b0 || {out_valid_o, in_ready_o, occ_o, out_ctrl_o, stall_cnt_o} !== exp_vec()) begin
                nfail++;
                $display("FAIL flush_no_d[%0d] got vld=%b lane0=%h exp vld=0", i, out_valid_o, out_data_o[15:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        cyc(0, 1, 11'h011, DW'(16'h0011), 0);
        cyc(0, 1, 11'h022, DW'(16'h0022), 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        nvec++;
        if ({out_valid_o, occ_o, out_ctrl_o, out_data_o, stall_cnt_o} !== '0) begin
            nfail++;
            $display("FAIL areset_now got vld=%b occ=%0d ctrl=%h stall=%0d exp all zero",
                     out_valid_o, occ_o, out_ctrl_o, stall_cnt_o);
        end
        in_valid_i = 1'b0;
        @(negedge clk_i);
        rst_n = 1'b1;
        #1;
        nvec++;
        if (in_ready_o !== 1'b1 || occ_o !== 2'd0 || stall_cnt_o !== '0) begin
            nfail++;
            $display("FAIL areset_release got rdy=%b occ=%0d stall=%0d exp 1/0/0", in_ready_o, occ_o, stall_cnt_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_stall_sat();
        cyc(0, 1, 11'h055, DW'(16'h0055), 0);
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 0, '0, '0, 0);
            nvec++;
            if (int'(stall_cnt_o) !== ((k < SMAX) ? k : SMAX) || out_valid_o !== 1'b1) begin
                nfail++;
                $display("FAIL stall_sat[%0d] got=%0d exp=%0d", k, stall_cnt_o, (k < SMAX) ? k : SMAX);
            end
        end
        cyc(0, 0, '0, '0, 1);
    endtask

    task automatic test_accept_pop();
        cyc(0, 1, 11'h0AA, DW'(16'h00AA), 1);
        cyc(0, 1, 11'h0BB, DW'(16'h00BB), 1);
        nvec++;
        if (occ_o !== 2'd1 || out_ctrl_o !== 11'h0BB || out_data_o[15:0] !== 16'h00BB) begin
            nfail++;
            $display("FAIL accept_pop got occ=%0d ctrl=%h lane0=%h exp 1/0bb/00bb", occ_o, out_ctrl_o, out_data_o[15:0]);
        end
        cyc(0, 0, '0, '0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 15) == 0), $urandom_range(0, 1), CTRL_W'($urandom()),
                rnd_data(), ($urandom_range(0, 2) != 0));
            nvec++;
            if ({out_valid_o, in_ready_o, occ_o, out_ctrl_o, stall_cnt_o} !== exp_vec()
                || (out_valid_o && out_data_o !== exp_data())) begin
                nfail++;
                $display("FAIL random[%0d] got st=%h data=%h exp st=%h data=%h", i,
                         {out_valid_o, in_ready_o, occ_o, out_ctrl_o, stall_cnt_o}, out_data_o,
                         exp_vec(), exp_data());
            end
        end
    endtask

    initial begin
        nvec = 0;
        nfail = 0;
        test_reset();
        test_pass_through();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_stall_sat();
        test_accept_pop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
